// File: rtl/strand_select_stage_rr.sv
// Issue stage for a multi-strand core.
// Picks one ready strand per cycle with a round-robin arbiter.
// Drives a registered issue packet (pc, instruction, lane, strand id) to decode.
// Handles suspend/resume, flush with lane rollback, multi-lane vector issue and downstream stall.
module strand_select_stage_rr #(
  parameter int NUM_STRANDS     = 4,
  parameter int STRAND_ID_WIDTH = 2,
  parameter int NUM_LANES       = 16,
  parameter int LANE_WIDTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_STRANDS-1:0]             strand_enable_i,
  input  logic [NUM_STRANDS*32-1:0]          instruction_i,
  input  logic [NUM_STRANDS*32-1:0]          pc_i,
  input  logic [NUM_STRANDS-1:0]             instruction_valid_i,
  input  logic [NUM_STRANDS-1:0]             multi_cycle_i,
  input  logic [NUM_STRANDS-1:0]             flush_i,
  input  logic [NUM_STRANDS*LANE_WIDTH-1:0]  rollback_reg_lane_i,
  input  logic [NUM_STRANDS-1:0]             suspend_strand_i,
  input  logic [NUM_STRANDS-1:0]             resume_strand_i,
  input  logic                               stall_i,
  output logic [NUM_STRANDS-1:0]             next_instruction_o,
  output logic                               issue_valid_o,
  output logic [31:0]                        pc_o,
  output logic [31:0]                        instruction_o,
  output logic [LANE_WIDTH-1:0]              reg_lane_select_o,
  output logic [STRAND_ID_WIDTH-1:0]         strand_id_o
);

  typedef enum logic {
    RUNNING   = 1'b0,
    SUSPENDED = 1'b1
  } strand_state_t;

  localparam logic [LANE_WIDTH-1:0]      LAST_LANE = LANE_WIDTH'(NUM_LANES - 1);
  localparam logic [STRAND_ID_WIDTH-1:0] LAST_ID   = STRAND_ID_WIDTH'(NUM_STRANDS - 1);

  logic [NUM_STRANDS-1:0]     req;
  logic [NUM_STRANDS-1:0]     grant;
  logic                       grant_any;
  logic [STRAND_ID_WIDTH-1:0] grant_id;
  logic [STRAND_ID_WIDTH-1:0] rr_ptr_reg;

  logic [31:0]           pc_arr    [NUM_STRANDS];
  logic [31:0]           instr_arr [NUM_STRANDS];
  logic [LANE_WIDTH-1:0] lane_sel  [NUM_STRANDS];

  // Per-strand run state, request qualification and lane counter.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STRANDS; gi++) begin : g_strand
      strand_state_t         state_reg, state_next;
      logic [LANE_WIDTH-1:0] lane_cnt_reg, lane_cnt_next;
      logic [LANE_WIDTH-1:0] rollback_lane;
      logic [LANE_WIDTH-1:0] issue_lane;
      logic                  consumed;

      assign pc_arr[gi]    = pc_i[gi*32 +: 32];
      assign instr_arr[gi] = instruction_i[gi*32 +: 32];
      assign rollback_lane = rollback_reg_lane_i[gi*LANE_WIDTH +: LANE_WIDTH];

      // Strand run state register.
      always_ff @(posedge clk) begin
        if (reset) state_reg <= RUNNING;
        else       state_reg <= state_next;
      end

      // Suspend takes priority over a simultaneous resume.
      always_comb begin
        state_next = state_reg;
        if (suspend_strand_i[gi])     state_next = SUSPENDED;
        else if (resume_strand_i[gi]) state_next = RUNNING;
      end

      // A strand asks for issue only when fully eligible and downstream can accept.
      assign req[gi] = strand_enable_i[gi] & instruction_valid_i[gi] &
                       (state_reg == RUNNING) & ~flush_i[gi] &
                       ~suspend_strand_i[gi] & ~stall_i & ~reset;

      // Lane selection, consumption and counter update for this strand.
      always_comb begin
        lane_cnt_next = lane_cnt_reg;
        issue_lane    = '0;
        consumed      = 1'b0;
        if (grant[gi]) begin
          if (multi_cycle_i[gi]) begin
            issue_lane = lane_cnt_reg;
            if (lane_cnt_reg == '0) begin
              consumed      = 1'b1;
              lane_cnt_next = LAST_LANE;
            end else begin
              lane_cnt_next = lane_cnt_reg - 1'b1;
            end
          end else begin
            consumed = 1'b1;
          end
        end else if (flush_i[gi] && !stall_i) begin
          // Rollback to lane 0 only makes sense for an instruction already mid-issue.
          if (rollback_lane == '0 && lane_cnt_reg == LAST_LANE) lane_cnt_next = LAST_LANE;
          else                                                  lane_cnt_next = rollback_lane;
        end
      end

      // Lane counter register; reset restarts any partial vector issue.
      always_ff @(posedge clk) begin
        if (reset) lane_cnt_reg <= LAST_LANE;
        else       lane_cnt_reg <= lane_cnt_next;
      end

      assign lane_sel[gi]           = issue_lane;
      assign next_instruction_o[gi] = consumed;
    end
  endgenerate

  // Round-robin search starting just after the last granted strand.
  always_comb begin
    int unsigned                cand_int;
    logic [STRAND_ID_WIDTH-1:0] cand;
    cand_int  = 0;
    cand      = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    for (int i = 1; i <= NUM_STRANDS; i++) begin
      cand_int = (int'(rr_ptr_reg) + i) % NUM_STRANDS;
      cand     = STRAND_ID_WIDTH'(cand_int);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)          rr_ptr_reg <= LAST_ID;
    else if (grant_any) rr_ptr_reg <= grant_id;
  end

  // Registered issue packet; holds under stall, NOP when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid_o     <= 1'b0;
      pc_o              <= '0;
      instruction_o     <= '0;
      reg_lane_select_o <= '0;
      strand_id_o       <= '0;
    end else if (!stall_i) begin
      if (grant_any) begin
        issue_valid_o     <= 1'b1;
        pc_o              <= pc_arr[grant_id];
        instruction_o     <= instr_arr[grant_id];
        reg_lane_select_o <= lane_sel[grant_id];
        strand_id_o       <= grant_id;
      end else begin
        issue_valid_o     <= 1'b0;
        pc_o              <= '0;
        instruction_o     <= '0;
        reg_lane_select_o <= '0;
        strand_id_o       <= '0;
      end
    end
  end

endmodule

// File: doc/strand_select_stage_rr.md
Name: strand_select_stage_rr

Overview:
Parametrised issue stage for a multi-strand core with NUM_STRANDS strands and a built-in round-robin arbiter. Each cycle it picks one ready strand from the per-strand instruction fetch interfaces and drives a registered issue packet to decode. It also handles per-strand suspend/resume, flush with lane rollback, multi-cycle vector issue (one lane per cycle), and a downstream stall.

Parameters:
NUM_STRANDS, 4, number of strands (≥2)
STRAND_ID_WIDTH, 2, width of strand id; must equal ceil(log2(NUM_STRANDS))
NUM_LANES, 16, lanes per multi-cycle vector instruction (power of 2)
LANE_WIDTH, 4, log2(NUM_LANES)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
strand_enable_i  in  NUM_STRANDS  per-strand enable mask
instruction_i  in  NUM_STRANDS*32  per-strand instruction; strand s at [s*32+:32]
pc_i  in  NUM_STRANDS*32  per-strand PC, same packing
instruction_valid_i  in  NUM_STRANDS  per-strand instruction valid
multi_cycle_i  in  NUM_STRANDS  instruction requires NUM_LANES issue cycles
flush_i  in  NUM_STRANDS  per-strand flush/rollback
rollback_reg_lane_i  in  NUM_STRANDS*LANE_WIDTH  lane to restart at on flush
suspend_strand_i  in  NUM_STRANDS  suspend strand
resume_strand_i  in  NUM_STRANDS  resume strand
stall_i  in  1  downstream cannot accept issue
next_instruction_o  out  NUM_STRANDS  combinational: strand's instruction fully consumed this cycle
issue_valid_o  out  1  registered issue packet valid
pc_o  out  32  issued PC
instruction_o  out  32  issued instruction (0 = NOP)
reg_lane_select_o  out  LANE_WIDTH  lane issued
strand_id_o  out  STRAND_ID_WIDTH  issued strand

Behaviour:
- Clock is clk. Reset is synchronous and active-high, on port reset.
- Reset: all outputs 0. All strands RUNNING. Lane counters = NUM_LANES-1. RR pointer = NUM_STRANDS-1, so strand 0 wins first.
- Per-strand state machine, RUNNING <-> SUSPENDED:
  - suspend_strand_i[s] -> SUSPENDED next cycle.
  - resume_strand_i[s] -> RUNNING next cycle.
  - If suspend and resume are asserted together, suspend wins.
- Request: req[s] = strand_enable_i[s] & instruction_valid_i[s] & RUNNING & !flush_i[s] & !suspend_strand_i[s] & !stall_i.
- Arbitration: combinational round-robin. Grant the first req[s] searching from pointer+1 upward, wrapping modulo NUM_STRANDS. At most one grant per cycle. Pointer <= granted index only when a grant occurs.
- Lane counter (per strand), on grant of s:
  - multi_cycle_i[s]=0: issue lane 0; next_instruction_o[s]=1; counter unchanged.
  - multi_cycle_i[s]=1: issue lane = counter[s]. If counter[s]==0: next_instruction_o[s]=1 and counter reloads NUM_LANES-1. Otherwise counter decrements and next_instruction_o[s]=0.
  - Lanes therefore issue descending NUM_LANES-1..0, interleaved with other strands by round-robin.
- next_instruction_o[s] is asserted only in a grant cycle for s. It is never asserted during stall_i, flush_i[s], or reset.
- flush_i[s]:
  - Counter[s] <= rollback_reg_lane_i[s], or NUM_LANES-1 if the rollback lane is 0 and the instruction is not mid-issue.
  - Strand s is not granted that cycle.
  - The state machine is affected only by a concurrent suspend/resume.
- Outputs are registered, 1-cycle latency from grant. On a grant edge, issue_valid_o=1 and the outputs carry the granted strand's pc, instruction, lane and id.
- No grant and !stall_i: issue_valid_o=0; pc/instruction/lane/strand_id = 0 (NOP).
- stall_i=1: all outputs, counters and pointer hold.
- Reset asserted mid multi-cycle issue: counters reload, and the partially issued instruction restarts from lane NUM_LANES-1 after reset.
- Strand disabled via strand_enable_i mid multi-cycle issue: its counter holds; issue resumes at the same lane when re-enabled.

Test Plan:
- Reset, then all 4 strands valid, single-cycle, pc_s=0x100*s -> issue order 0,1,2,3,0. Each issue_valid_o=1 one cycle after grant. next_instruction_o one-hot in the grant cycle.
- Only strand 2 valid, multi_cycle=1 -> 16 consecutive issues, reg_lane_select_o 15..0. next_instruction_o[2] only on lane 0. Then the counter reads 15 again.
- Strands 0 and 1 both multi-cycle -> lanes interleave 0:15, 1:15, 0:14, 1:14 ... until each reaches lane 0.
- Strand 1 at lane 9; assert flush_i[1]+suspend_strand_i[1] with rollback lane 9 -> no strand-1 issue while suspended. resume_strand_i[1] -> next strand-1 issue has lane 9.
- stall_i held 3 cycles mid-stream -> outputs and pointer frozen, no next_instruction_o. After release, round-robin continues from the same pointer.
- No strand valid, or strand_enable_i=0 -> issue_valid_o=0, instruction_o=0, strand_id_o=0 every cycle. Reset asserted mid-stream -> all outputs 0 next edge and strand 0 wins first afterwards.
